// File: rtl/sram_axis_reader.sv
// sram_axis_reader: streams a contiguous block of one SRAM bank out as
// AXI4-Stream beats. Reads are issued under a credit rule so the local
// read-data FIFO can never overflow, whatever the downstream backpressure.
module sram_axis_reader #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int MAX_ADDR_WIDTH     = 8,
    parameter int NUM_SRAMS          = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [NUM_SRAMS-1:0]                   src_idx,
    input  logic [MAX_ADDR_WIDTH-1:0]              base_addr,
    input  logic [MAX_ADDR_WIDTH:0]                length,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   sram_out_en,
    output logic [NUM_SRAMS-1:0]                   sram_out_idx,
    output logic [MAX_ADDR_WIDTH-1:0]              sram_out_addr,
    input  logic signed [2*C_AXIS_TDATA_WIDTH-1:0] sram_out_data,
    output logic [2*C_AXIS_TDATA_WIDTH-1:0]        m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast
);

    localparam int BW = 2 * C_AXIS_TDATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = MAX_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   words_rem;
    logic [LW-1:0]   out_cnt;

    // Read-data FIFO
    logic [BW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Capture strobe: high in the cycle the SRAM drives the data for a read
    logic            cap_vld_p1;

    logic            push;
    logic            pop;
    logic [CW-1:0]   count_next;
    logic [CW:0]     credit_sum;
    logic            credit_ok;
    logic            last_hs;

    assign push          = cap_vld_p1;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt == (len_q - LW'(1)));
    assign last_hs       = pop && m_axis_tlast;

    // Credit for the next issue: FIFO occupancy after this edge plus the read
    // currently on the SRAM port must leave room for one more word.
    assign count_next = count + CW'(push) - CW'(pop);
    assign credit_sum = {1'b0, count_next} + (CW + 1)'(sram_out_en);
    assign credit_ok  = credit_sum < (CW + 1)'(FIFO_DEPTH);

    // Control FSM: accepts requests, issues reads, tracks beats and signals completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            sram_out_en   <= 1'b0;
            sram_out_idx  <= '0;
            sram_out_addr <= '0;
            len_q         <= '0;
            words_rem     <= '0;
            out_cnt       <= '0;
        end else begin
            done        <= 1'b0;
            sram_out_en <= 1'b0;
            if (pop) begin
                out_cnt <= out_cnt + LW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            // First read goes out in the cycle right after start
                            sram_out_idx  <= src_idx;
                            sram_out_addr <= base_addr;
                            len_q         <= length;
                            words_rem     <= length - LW'(1);
                            out_cnt       <= '0;
                            sram_out_en   <= 1'b1;
                            busy          <= 1'b1;
                            state         <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (words_rem == '0) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        sram_out_en   <= 1'b1;
                        sram_out_addr <= sram_out_addr + MAX_ADDR_WIDTH'(1);
                        words_rem     <= words_rem - LW'(1);
                    end
                end
                DRAIN: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Final beat accepted downstream: the transfer is complete
            if (last_hs) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    // Capture pipeline: SRAM data is valid one cycle after the read enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld_p1 <= 1'b0;
        end else begin
            cap_vld_p1 <= sram_out_en;
        end
    end

    // FIFO storage and pointers; push and pop may happen in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_out_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_sram_axis_reader.sv
// Scoreboard bench for sram_axis_reader: the stimulus side queues expected
// read addresses and beats; monitors compare them as the DUT presents them.
module tb_sram_axis_reader;

    localparam int AW    = 8;
    localparam int NS    = 4;
    localparam int DEPTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [NS-1:0]         src_idx;
    logic [AW-1:0]         base_addr;
    logic [AW:0]           length;
    logic                  busy;
    logic                  done;
    logic                  sram_out_en;
    logic [NS-1:0]         sram_out_idx;
    logic [AW-1:0]         sram_out_addr;
    logic signed [15:0]    sram_out_data;
    logic [15:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    sram_axis_reader #(
        .C_AXIS_TDATA_WIDTH(8),
        .FIFO_DEPTH(DEPTH),
        .MAX_ADDR_WIDTH(AW),
        .NUM_SRAMS(NS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_idx(src_idx),
        .base_addr(base_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .sram_out_en(sram_out_en),
        .sram_out_idx(sram_out_idx),
        .sram_out_addr(sram_out_addr),
        .sram_out_data(sram_out_data),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0]    mem [256];
    logic [AW-1:0]  addr_q [$];
    logic [16:0]    exp_q  [$];
    logic [NS-1:0]  exp_idx;
    logic           zl_expect;
    int             tready_mode;   // 0: always ready, 1: toggle, 2: never
    int             beats_seen;
    int             done_cnt;
    int             max_occ;
    int             run_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // SRAM read port model: one-cycle read latency
    always @(posedge clk) begin
        if (sram_out_en) sram_out_data <= mem[sram_out_addr];
    end

    // Downstream ready pattern
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: read addresses, beats, stability under stall, done timing, occupancy
    initial begin
        int          issued, popped, occ;
        logic        prev_stall, prev_hs, prev_tlast_hs;
        logic [15:0] prev_d;
        logic        prev_l;
        logic [AW-1:0] ea;
        logic [16:0] eb;
        issued = 0; popped = 0; prev_stall = 0; prev_hs = 0; prev_tlast_hs = 0;
        prev_d = '0; prev_l = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                issued = 0; popped = 0; prev_stall = 0; prev_hs = 0; prev_tlast_hs = 0;
            end else begin
                if (sram_out_en) begin
                    issued++;
                    if (addr_q.size() == 0) begin
                        chk("unexpected_read", 32'(sram_out_addr), 32'hFFFF_FFFF);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("rd_addr", 32'(sram_out_addr), 32'(ea));
                        chk("rd_idx", 32'(sram_out_idx), 32'(exp_idx));
                    end
                end
                occ = issued - popped;
                if (occ > max_occ) max_occ = occ;
                if (prev_stall) begin
                    chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                    chk("stall_tdata", 32'(m_axis_tdata), 32'(prev_d));
                    chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_l));
                end
                if (done) begin
                    done_cnt++;
                    chk("done_timing", 32'(prev_tlast_hs || zl_expect), 32'd1);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    popped++;
                    beats_seen++;
                    run_len = prev_hs ? run_len + 1 : 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("beat_data", 32'(m_axis_tdata), 32'(eb[15:0]));
                        chk("beat_last", 32'(m_axis_tlast), 32'(eb[16]));
                    end
                end
                prev_stall    = m_axis_tvalid && !m_axis_tready;
                prev_hs       = m_axis_tvalid && m_axis_tready;
                prev_tlast_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
                prev_d        = m_axis_tdata;
                prev_l        = m_axis_tlast;
            end
        end
    end

    // Queue expected reads and beats for one transfer
    task automatic expect_xfer(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), mem[a]});
        end
    endtask

    // Pulse start for one cycle; returns in the cycle after start (cycle 1)
    task automatic do_start(input logic [NS-1:0] idx, input logic [AW-1:0] base, input int len);
        @(posedge clk);
        #1;
        start     = 1'b1;
        src_idx   = idx;
        base_addr = base;
        length    = (AW + 1)'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then confirm the transfer fully drained
    task automatic finish_xfer(input string name, input int done_before);
        int waited;
        waited = 0;
        while (done_cnt == done_before && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt - done_before), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
        chk({name, "_done_once"}, 32'(done_cnt - done_before), 32'd1);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, b0, waited;
        rst = 1'b0; start = 1'b0; src_idx = '0; base_addr = '0; length = '0;
        exp_idx = '0; zl_expect = 1'b0; tready_mode = 0;
        beats_seen = 0; done_cnt = 0; max_occ = 0; run_len = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0002;
        mem[8'h12] = 16'h0003; mem[8'h13] = 16'h0004;

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(sram_out_en), 0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tlast", 32'(m_axis_tlast), 0);
        chk("rst_addr_idx", {sram_out_idx, 4'h0, sram_out_addr}, 0);
        chk("rst_tdata", 32'(m_axis_tdata), 0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: bank 1, base 0x10, 4 words, always ready
        exp_idx = 4'b0010;
        expect_xfer(8'h10, 4);
        d0 = done_cnt;
        do_start(4'b0010, 8'h10, 4);
        chk("t1_c1_en", 32'(sram_out_en), 1);
        chk("t1_c1_busy", 32'(busy), 1);
        chk("t1_c1_tvalid", 32'(m_axis_tvalid), 0);
        @(posedge clk); #1;
        chk("t1_c2_tvalid", 32'(m_axis_tvalid), 0);
        @(posedge clk); #1;
        chk("t1_c3_tvalid", 32'(m_axis_tvalid), 1);
        chk("t1_c3_tdata", 32'(m_axis_tdata), 32'h0001);
        finish_xfer("t1", d0);
        chk("t1_back_to_back", 32'(run_len), 32'd4);

        // 2: 8 words with ready toggling every cycle
        tready_mode = 1;
        expect_xfer(8'h40, 8);
        d0 = done_cnt;
        do_start(4'b0010, 8'h40, 8);
        finish_xfer("t2", d0);
        chk("t2_credit", 32'(max_occ <= DEPTH), 1);
        tready_mode = 0;

        // 3: address wrap at the top of the bank
        exp_idx = 4'b0100;
        expect_xfer(8'hFE, 4);
        d0 = done_cnt;
        do_start(4'b0100, 8'hFE, 4);
        finish_xfer("t3", d0);

        // 4: zero-length request
        zl_expect = 1'b1;
        d0 = done_cnt;
        do_start(4'b0100, 8'h20, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_en", 32'(sram_out_en), 0);
        @(posedge clk); #1;
        chk("t4_done_pulse", 32'(done), 0);
        chk("t4_tvalid", 32'(m_axis_tvalid), 0);
        zl_expect = 1'b0;

        // 5: start during a transfer is ignored
        exp_idx = 4'b0001;
        expect_xfer(8'h20, 6);
        d0 = done_cnt;
        do_start(4'b0001, 8'h20, 6);
        do_start(4'b1000, 8'h80, 3);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_idx_held", 32'(sram_out_idx), 32'(4'b0001));
        finish_xfer("t5", d0);

        // 6: reset after 3 beats, then a fresh transfer
        exp_idx = 4'b0010;
        expect_xfer(8'h30, 8);
        b0 = beats_seen;
        do_start(4'b0010, 8'h30, 8);
        waited = 0;
        while (beats_seen - b0 < 3 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        chk("t6_three_beats", 32'(beats_seen - b0), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_en", 32'(sram_out_en), 0);
        chk("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("t6_rst_tlast", 32'(m_axis_tlast), 0);
        chk("t6_rst_addr", 32'(sram_out_addr), 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        expect_xfer(8'h50, 3);
        d0 = done_cnt;
        do_start(4'b0010, 8'h50, 3);
        finish_xfer("t6", d0);
        chk("final_credit", 32'(max_occ <= DEPTH), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
